// File: rtl/wb_stage_if.sv
// MEM -> WB pipeline bus: the valid/allowin handshake plus every field MEM hands to WB.
interface wb_stage_if;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_alu_result;
    logic [4:0]  ms_ld_op;
    logic [31:0] ms_mem_rdata;
    logic        ms_ex;
    logic [5:0]  ms_ecode;
    logic [8:0]  ms_esubcode;
    logic [31:0] ms_vaddr;
    logic        ms_ertn;
    logic        ms_csr_we;
    logic [13:0] ms_csr_num;
    logic [31:0] ms_csr_wmask;
    logic [31:0] ms_csr_wvalue;

    modport master (
        output ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_alu_result, ms_ld_op,
               ms_mem_rdata, ms_ex, ms_ecode, ms_esubcode, ms_vaddr, ms_ertn,
               ms_csr_we, ms_csr_num, ms_csr_wmask, ms_csr_wvalue,
        input  ws_allowin
    );

    modport slave (
        input  ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_alu_result, ms_ld_op,
               ms_mem_rdata, ms_ex, ms_ecode, ms_esubcode, ms_vaddr, ms_ertn,
               ms_csr_we, ms_csr_num, ms_csr_wmask, ms_csr_wvalue,
        output ws_allowin
    );
endinterface

// File: rtl/wb_stage.sv
// LoongArch32 write-back stage: load extraction, GPR/CSR commit, exception/ertn flush.
// Optional macro WB_DEBUG_TRACE_EN adds the debug_wb_* commit trace outputs.
module wb_stage #(
    parameter int unsigned FLUSH_SHADOW = 1
) (
    input  logic        clk,
    input  logic        reset,
    wb_stage_if.slave   ms,
`ifdef WB_DEBUG_TRACE_EN
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
`endif
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        ws_fwd_valid,
    output logic [4:0]  ws_fwd_dest,
    output logic [31:0] ws_fwd_data,
    output logic        ws_csr_busy,
    output logic        csr_we,
    output logic [13:0] csr_num,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        wb_ex,
    output logic        ertn_flush,
    output logic [31:0] wb_pc,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_vaddr,
    input  logic [31:0] ex_entry,
    input  logic [31:0] ertn_entry,
    output logic        ws_flush,
    output logic [31:0] ws_flush_target
);

    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [4:0]  ld_op;
        logic [31:0] mem_rdata;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] vaddr;
        logic        ertn;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
    } ws_regs_t;

    ws_regs_t    ms_in;
    ws_regs_t    ws_q;
    logic        ws_valid;
    logic [1:0]  shadow_cnt;
    logic        ws_ready_go;
    logic        allowin;
    logic        accept;
    logic        drop;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign ms_in = '{
        pc:         ms.ms_pc,
        gr_we:      ms.ms_gr_we,
        dest:       ms.ms_dest,
        alu_result: ms.ms_alu_result,
        ld_op:      ms.ms_ld_op,
        mem_rdata:  ms.ms_mem_rdata,
        ex:         ms.ms_ex,
        ecode:      ms.ms_ecode,
        esubcode:   ms.ms_esubcode,
        vaddr:      ms.ms_vaddr,
        ertn:       ms.ms_ertn,
        csr_we:     ms.ms_csr_we,
        csr_num:    ms.ms_csr_num,
        csr_wmask:  ms.ms_csr_wmask,
        csr_wvalue: ms.ms_csr_wvalue
    };

    assign ws_ready_go   = 1'b1;
    assign allowin       = !ws_valid || ws_ready_go;
    assign ms.ws_allowin = allowin;
    assign accept        = ms.ms_to_ws_valid && allowin;
    // Anything arriving on a flush edge or inside the shadow window is a wrong-path instruction.
    assign drop          = ws_flush || (shadow_cnt != 2'd0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid   <= 1'b0;
            shadow_cnt <= 2'd0;
            ws_q       <= '0;
        end else begin
            if (accept) begin
                ws_valid <= !drop;
                ws_q     <= ms_in;
            end else begin
                ws_valid <= 1'b0;
            end

            if (ws_flush) begin
                shadow_cnt <= 2'(FLUSH_SHADOW);
            end else if (shadow_cnt != 2'd0) begin
                shadow_cnt <= shadow_cnt - 2'd1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        ld_byte = ws_q.mem_rdata[7:0];
        unique case (ws_q.alu_result[1:0])
            2'd0: ld_byte = ws_q.mem_rdata[7:0];
            2'd1: ld_byte = ws_q.mem_rdata[15:8];
            2'd2: ld_byte = ws_q.mem_rdata[23:16];
            2'd3: ld_byte = ws_q.mem_rdata[31:24];
        endcase
        ld_half = ws_q.alu_result[1] ? ws_q.mem_rdata[31:16] : ws_q.mem_rdata[15:0];

        // ld_op is one-hot {ld.w, ld.hu, ld.h, ld.bu, ld.b}; zero selects the ALU result.
        ld_data = ws_q.alu_result;
        if (ws_q.ld_op[0])      ld_data = {{24{ld_byte[7]}}, ld_byte};
        else if (ws_q.ld_op[1]) ld_data = {24'd0, ld_byte};
        else if (ws_q.ld_op[2]) ld_data = {{16{ld_half[15]}}, ld_half};
        else if (ws_q.ld_op[3]) ld_data = {16'd0, ld_half};
        else if (ws_q.ld_op[4]) ld_data = ws_q.mem_rdata;
    end

    assign wb_ex           = ws_valid & ws_q.ex;
    assign ertn_flush      = ws_valid & ws_q.ertn & ~ws_q.ex;
    assign ws_flush        = wb_ex | ertn_flush;
    assign ws_flush_target = wb_ex ? ex_entry : ertn_entry;
    assign wb_pc           = ws_q.pc;
    assign wb_ecode        = ws_q.ecode;
    assign wb_esubcode     = ws_q.esubcode;
    assign wb_vaddr        = ws_q.vaddr;

    assign rf_we    = ws_valid & ws_q.gr_we & ~ws_q.ex & (ws_q.dest != 5'd0);
    assign rf_waddr = ws_q.dest;
    assign rf_wdata = ld_data;

    assign csr_we     = ws_valid & ws_q.csr_we & ~ws_q.ex;
    assign csr_num    = ws_q.csr_num;
    assign csr_wmask  = ws_q.csr_wmask;
    assign csr_wvalue = ws_q.csr_wvalue;

    assign ws_fwd_valid = rf_we;
    assign ws_fwd_dest  = ws_q.dest;
    assign ws_fwd_data  = rf_wdata;
    assign ws_csr_busy  = ws_valid & (ws_q.csr_we | ws_q.ertn | ws_q.ex);

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = wb_pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule
